// File: rtl/rf_hazard_ctrl.sv
// rf_hazard_ctrl: scoreboard-based hazard, forwarding and squash control for the register-file datapath.
// Define RF_HAZARD_FWD_EN for operand forwarding; when undefined, dependents interlock until the writer retires.
`ifndef RF_WSEL_RDO
`define RF_WSEL_RDO 2'd1
`endif

module rf_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_we,
    input  logic [1:0]        id_wsel,
    input  logic              ex_redirect,
    output logic              stall,
    output logic              bubble,
    output logic              flush_ifid,
    output logic [1:0]        fwd_rs1_sel,
    output logic [1:0]        fwd_rs2_sel,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam int EX  = 0;
    localparam int MEM = 1;
    localparam int WB  = 2;

    // scoreboard slots: index 0 = EX, 1 = MEM, 2 = WB
    logic [2:0]             sb_v;
    logic [2:0]             sb_we;
    logic [2:0][REG_AW-1:0] sb_rd;
    logic                   ex_ld;

    logic [2:0] hit1;
    logic [2:0] hit2;
    logic       luh;
    logic       alu1;
    logic       alu2;
    logic       hazard;

    always_comb begin
        hit1 = '0;
        hit2 = '0;
        for (int k = 0; k < 3; k++) begin
            hit1[k] = id_valid & id_rs1_used & sb_v[k] & sb_we[k]
                      & (sb_rd[k] == id_rs1) & (id_rs1 != '0);
            hit2[k] = id_valid & id_rs2_used & sb_v[k] & sb_we[k]
                      & (sb_rd[k] == id_rs2) & (id_rs2 != '0);
        end
    end

    assign luh  = ex_ld & (hit1[EX] | hit2[EX]);
    assign alu1 = hit1[EX] & ~ex_ld;
    assign alu2 = hit2[EX] & ~ex_ld;

`ifdef RF_HAZARD_FWD_EN
    assign hazard = luh;

    always_comb begin
        fwd_rs1_sel = 2'd0;
        if (alu1)           fwd_rs1_sel = 2'd1;
        else if (hit1[MEM]) fwd_rs1_sel = 2'd2;
        else if (hit1[WB])  fwd_rs1_sel = 2'd3;
    end

    always_comb begin
        fwd_rs2_sel = 2'd0;
        if (alu2)           fwd_rs2_sel = 2'd1;
        else if (hit2[MEM]) fwd_rs2_sel = 2'd2;
        else if (hit2[WB])  fwd_rs2_sel = 2'd3;
    end
`else
    // no bypass and no write-through: any in-flight writer of a used source blocks ID
    assign hazard = luh | alu1 | alu2 | hit1[MEM] | hit1[WB] | hit2[MEM] | hit2[WB];
    assign fwd_rs1_sel = 2'd0;
    assign fwd_rs2_sel = 2'd0;
`endif

    // redirect outranks the interlock: the ID instruction is dropped, not held
    assign stall      = rst_n & hazard & ~ex_redirect;
    assign bubble     = rst_n & (hazard | ex_redirect);
    assign flush_ifid = ex_redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_v  <= '0;
            sb_we <= '0;
            sb_rd <= '0;
            ex_ld <= 1'b0;
        end else begin
            sb_v  <= {sb_v[1:0], id_valid & ~bubble};
            sb_we <= {sb_we[1:0], id_we};
            sb_rd <= {sb_rd[1:0], id_rd};
            ex_ld <= (id_wsel == `RF_WSEL_RDO);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stall)
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_rf_hazard_ctrl.sv
// Bench for rf_hazard_ctrl: per-cycle comparison against an in-flight-producer model plus literal pins.
`ifndef RF_WSEL_RDO
`define RF_WSEL_RDO 2'd1
`endif

module tb_rf_hazard_ctrl;
    localparam int AW = 5;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          id_valid = 1'b0;
    logic [AW-1:0] id_rs1 = '0;
    logic [AW-1:0] id_rs2 = '0;
    logic          id_rs1_used = 1'b0;
    logic          id_rs2_used = 1'b0;
    logic [AW-1:0] id_rd = '0;
    logic          id_we = 1'b0;
    logic [1:0]    id_wsel = 2'd0;
    logic          ex_redirect = 1'b0;
    logic          stall, bubble, flush_ifid;
    logic [1:0]    fwd_rs1_sel, fwd_rs2_sel;
    logic [CW-1:0] stall_cnt;

    rf_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_we(id_we), .id_wsel(id_wsel),
        .ex_redirect(ex_redirect),
        .stall(stall), .bubble(bubble), .flush_ifid(flush_ifid),
        .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] rs1;
        logic [AW-1:0] rs2;
        logic          u1;
        logic          u2;
        logic [AW-1:0] rd;
        logic          we;
        logic [1:0]    wsel;
        logic          redir;
    } instr_t;

    typedef struct packed {
        logic          v;
        logic [AW-1:0] rd;
        logic          we;
        logic          ld;
    } slot_t;

    int checks = 0;
    int failures = 0;

    // model: instructions that entered EX 1, 2 and 3 cycles ago
    slot_t         age [1:3];
    logic [CW-1:0] m_cnt;
    logic          e_haz, e_stall, e_bubble;
    logic [1:0]    e_sel1, e_sel2;

    function automatic bit produces(slot_t s, logic [AW-1:0] r);
        return s.v && s.we && (s.rd == r) && (r != 0);
    endfunction

    always_comb begin
        e_haz  = 1'b0;
        e_sel1 = 2'd0;
        e_sel2 = 2'd0;
        for (int a = 1; a <= 3; a++) begin
            if (id_valid && id_rs1_used && produces(age[a], id_rs1)) begin
`ifdef RF_HAZARD_FWD_EN
                if (a == 1 && age[1].ld) e_haz = 1'b1;
                else if (e_sel1 == 2'd0) e_sel1 = 2'(a);
`else
                e_haz = 1'b1;
`endif
            end
            if (id_valid && id_rs2_used && produces(age[a], id_rs2)) begin
`ifdef RF_HAZARD_FWD_EN
                if (a == 1 && age[1].ld) e_haz = 1'b1;
                else if (e_sel2 == 2'd0) e_sel2 = 2'(a);
`else
                e_haz = 1'b1;
`endif
            end
        end
        e_stall  = rst_n && e_haz && !ex_redirect;
        e_bubble = rst_n && (e_haz || ex_redirect);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 1; a <= 3; a++) age[a] <= '0;
            m_cnt <= '0;
        end else begin
            age[3] <= age[2];
            age[2] <= age[1];
            age[1] <= '{v: id_valid && !e_bubble, rd: id_rd, we: id_we,
                        ld: (id_wsel == `RF_WSEL_RDO)};
            if (e_stall) m_cnt <= m_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("stall", 32'(stall), 32'(e_stall));
        chk("bubble", 32'(bubble), 32'(e_bubble));
        chk("flush_ifid", 32'(flush_ifid), 32'(ex_redirect));
        chk("fwd_rs1_sel", 32'(fwd_rs1_sel), 32'(e_sel1));
        chk("fwd_rs2_sel", 32'(fwd_rs2_sel), 32'(e_sel2));
        chk("stall_cnt", stall_cnt, m_cnt);
    end

    function automatic instr_t alu(input int rd, input int rs1, input int rs2);
        return '{valid: 1'b1, rs1: AW'(rs1), rs2: AW'(rs2), u1: 1'b1, u2: 1'b1,
                 rd: AW'(rd), we: 1'b1, wsel: 2'd0, redir: 1'b0};
    endfunction

    function automatic instr_t lw(input int rd, input int rs1);
        return '{valid: 1'b1, rs1: AW'(rs1), rs2: '0, u1: 1'b1, u2: 1'b0,
                 rd: AW'(rd), we: 1'b1, wsel: `RF_WSEL_RDO, redir: 1'b0};
    endfunction

    function automatic instr_t lui(input int rd, input int field);
        return '{valid: 1'b1, rs1: AW'(field), rs2: AW'(field), u1: 1'b0, u2: 1'b0,
                 rd: AW'(rd), we: 1'b1, wsel: 2'd0, redir: 1'b0};
    endfunction

    task automatic apply(input instr_t i);
        id_valid    = i.valid;
        id_rs1      = i.rs1;
        id_rs2      = i.rs2;
        id_rs1_used = i.u1;
        id_rs2_used = i.u2;
        id_rd       = i.rd;
        id_we       = i.we;
        id_wsel     = i.wsel;
        ex_redirect = i.redir;
    endtask

    // present one instruction in ID, holding it while the model says stall
    task automatic issue(input instr_t i, output int n_stall, output logic [1:0] s1,
                         output logic [1:0] s2, output logic b0, output logic f0);
        bit hold;
        hold = 1'b1;
        n_stall = 0;
        s1 = 2'd0; s2 = 2'd0; b0 = 1'b0; f0 = 1'b0;
        apply(i);
        for (int n = 0; n < 8 && hold; n++) begin
            @(negedge clk);
            if (n == 0) begin b0 = bubble; f0 = flush_ifid; end
            s1 = fwd_rs1_sel;
            s2 = fwd_rs2_sel;
            if (stall) n_stall++;
            hold = e_stall;
            @(posedge clk);
            #1;
        end
        if (hold) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout actual=stalled required=released t=%0t", $time);
        end
        ex_redirect = 1'b0;
    endtask

    task automatic run(input instr_t i);
        int ns; logic [1:0] a, b; logic c, d;
        issue(i, ns, a, b, c, d);
    endtask

    task automatic flush3();
        for (int k = 0; k < 3; k++) run(alu(0, 0, 0));
    endtask

    int         ns;
    logic [1:0] s1, s2;
    logic       b0, f0;
    int         lit_cnt;

`ifdef RF_HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    initial begin
        lit_cnt = 0;
        // reset held with a live instruction in ID
        apply(alu(6, 5, 5));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_bubble", 32'(bubble), 32'd0);
        chk("rst_sel1", 32'(fwd_rs1_sel), 32'd0);
        chk("rst_sel2", 32'(fwd_rs2_sel), 32'd0);
        chk("rst_cnt", stall_cnt, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(alu(6, 5, 5), ns, s1, s2, b0, f0);
        chk("post_rst_stalls", 32'(ns), 32'd0);
        flush3();

        // ALU chain with 0..3 NOPs between producer and consumer
        for (int gap = 0; gap <= 3; gap++) begin
            run(alu(5, 1, 2));
            for (int g = 0; g < gap; g++) run(alu(0, 0, 0));
            issue(alu(6, 5, 5), ns, s1, s2, b0, f0);
            if (FWD) begin
                chk($sformatf("alu_gap%0d_stalls", gap), 32'(ns), 32'd0);
                chk($sformatf("alu_gap%0d_sel1", gap), 32'(s1), (gap == 3) ? 32'd0 : 32'(gap + 1));
                chk($sformatf("alu_gap%0d_sel2", gap), 32'(s2), (gap == 3) ? 32'd0 : 32'(gap + 1));
            end else begin
                chk($sformatf("alu_gap%0d_stalls", gap), 32'(ns), 32'(3 - gap));
                chk($sformatf("alu_gap%0d_sel1", gap), 32'(s1), 32'd0);
                lit_cnt += 3 - gap;
            end
            flush3();
        end
        @(negedge clk);
        chk("cnt_after_alu", stall_cnt, 32'(lit_cnt));

        // load-use
        run(lw(7, 2));
        issue(alu(8, 7, 1), ns, s1, s2, b0, f0);
        chk("lu_bubble", 32'(b0), 32'd1);
        if (FWD) begin
            chk("lu_stalls", 32'(ns), 32'd1);
            chk("lu_sel1", 32'(s1), 32'd2);
            chk("lu_sel2", 32'(s2), 32'd0);
            lit_cnt += 1;
        end else begin
            chk("lu_stalls", 32'(ns), 32'd3);
            lit_cnt += 3;
        end
        @(negedge clk);
        chk("cnt_after_lu", stall_cnt, 32'(lit_cnt));
        flush3();

        // x0 destination and unused source field
        run(lw(0, 2));
        issue(alu(8, 0, 0), ns, s1, s2, b0, f0);
        chk("x0_stalls", 32'(ns), 32'd0);
        chk("x0_sel1", 32'(s1), 32'd0);
        flush3();
        run(lw(9, 2));
        issue(lui(10, 9), ns, s1, s2, b0, f0);
        chk("lui_stalls", 32'(ns), 32'd0);
        chk("lui_sel1", 32'(s1), 32'd0);
        flush3();

        // redirect in the same cycle as a load-use hazard
        run(lw(7, 2));
        begin
            instr_t r;
            r = alu(8, 7, 1);
            r.redir = 1'b1;
            issue(r, ns, s1, s2, b0, f0);
        end
        chk("redir_stalls", 32'(ns), 32'd0);
        chk("redir_bubble", 32'(b0), 32'd1);
        chk("redir_flush", 32'(f0), 32'd1);
        issue(alu(11, 8, 8), ns, s1, s2, b0, f0);
        chk("redir_killed_stalls", 32'(ns), 32'd0);
        chk("redir_killed_sel1", 32'(s1), 32'd0);
        flush3();
        @(negedge clk);
        chk("cnt_after_redir", stall_cnt, 32'(lit_cnt));

        // reset asserted in the middle of a stall
        run(lw(7, 2));
        apply(alu(8, 7, 1));
        @(negedge clk);
        chk("mid_stall_pre", 32'(stall), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_cnt", stall_cnt, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_mid_rst_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        flush3();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end
endmodule

// File: doc/rf_hazard_ctrl.md
Name: rf_hazard_ctrl

Overview:
Hazard and forwarding controller for the register-file datapath of the 5-stage pipeline (ID reads rs1/rs2; WB writes through the rf_wsel mux).
Tracks in-flight destination registers of the EX/MEM/WB stages in an internal 3-deep scoreboard shift register.
Drives ID-stage operand forwarding selects, load-use stall, bubble insertion and branch-redirect squash.
Also keeps a stall-cycle performance counter.

Parameters:
REG_AW, 5, register address width (32 architectural registers, x0 hard-wired zero)
CNT_W, 32, width of stall_cnt performance counter

Ports:
clk  input  1  pipeline clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
id_valid  input  1  ID stage holds a real instruction
id_rs1  input  REG_AW  ID source register 1 (din[19:15])
id_rs2  input  REG_AW  ID source register 2 (din[24:20])
id_rs1_used  input  1  instruction reads rs1
id_rs2_used  input  1  instruction reads rs2
id_rd  input  REG_AW  ID destination register
id_we  input  1  ID instruction writes RF (rf_we)
id_wsel  input  2  ID write-back source; load iff equal to `RF_WSEL_RDO
ex_redirect  input  1  branch/jump resolved taken in EX this cycle
stall  output  1  hold PC and IF/ID register (combinational)
bubble  output  1  load NOP into ID/EX (combinational)
flush_ifid  output  1  squash IF/ID (combinational, = ex_redirect)
fwd_rs1_sel  output  2  0=RF rD1, 1=EX alu_c, 2=MEM wb data, 3=WB rf_wD
fwd_rs2_sel  output  2  same encoding for rD2
stall_cnt  output  CNT_W  count of cycles with stall=1

Behaviour:
- Scoreboard entries EX, MEM, WB each {v, rd, we, ld}; ld = (wsel==`RF_WSEL_RDO).
- Entry "writes r" iff v & we & rd==r & r!=0.
- Reset (async, rst_n=0): all v=0, stall_cnt=0; outputs stall=0, bubble=0, fwd sels=0 while in reset.
- Load-use hazard luh = id_valid & EX.ld & EX writes (id_rs1 if rs1_used, or id_rs2 if rs2_used).
- stall = luh & ~ex_redirect. bubble = luh | ex_redirect. flush_ifid = ex_redirect.
- Per-cycle update: WB<=MEM, MEM<=EX; EX<=ID fields with v=id_valid, unless bubble, in which case EX.v<=0.
- ex_redirect has priority over luh: no stall, ID instruction killed (EX.v<=0), branch itself advances to MEM normally.
- Forward select (rs1, rs2 independently, only if *_used and id_valid): EX writes rs & ~EX.ld -> 1; else MEM writes rs -> 2; else WB writes rs -> 3; else 0. Youngest wins.
- rs==0 always selects 0.
- Latency: luh produces exactly one stall cycle; next cycle the load is in MEM and selects 2.
- stall_cnt increments by 1 each cycle stall=1; wraps modulo 2^CNT_W.
- Reset asserted mid-stall: all entries clear immediately; first cycle after release stall=0.

Optional Feature:
RF_HAZARD_FWD_EN. Defined: forwarding as above.
Undefined: fwd_rs1_sel/fwd_rs2_sel tied 0. stall asserts whenever any EX, MEM or WB entry writes a used source register (not only loads). The RF write is not write-through, so WB also stalls. Bubble/redirect rules are unchanged; a dependent instruction after an ALU op stalls 3 cycles.

Test Plan:
- Reset: hold rst_n=0 with id_valid=1 -> stall=0, bubble=0, fwd sels=0, stall_cnt=0; release -> first stall only on real hazard.
- ALU chain: add x5 then add x6,x5,x5 back-to-back -> fwd_rs1_sel=fwd_rs2_sel=1, stall=0. With one NOP between -> sel=2. With two NOPs -> sel=3. With three NOPs -> sel=0.
- Load-use: lw x7 then add x8,x7,x1 -> stall=1 and bubble=1 for exactly 1 cycle, stall_cnt=1; next cycle fwd_rs1_sel=2, fwd_rs2_sel=0.
- x0 / unused: lw x0 then add using x0 -> no stall, sel 0. lw x9 then lui (rs1_used=0) reading field 9 -> no stall.
- Redirect vs load-use: ex_redirect=1 in the same cycle as luh -> stall=0, bubble=1, flush_ifid=1; EX entry invalid next cycle.
- Macro undefined: add x5 then add x6,x5 -> stall high 3 cycles, sels 0, stall_cnt=3.
